aes128_key_expand_ctrl: RTL and testbench

Sequential, area-reduced replacement for the fully unrolled AES-128 key schedule. It accepts a 128-bit cipher key over a valid/ready handshake. It then iterates one shared RotWord/SubWord/Rcon stage (the existing keyOperations unit) for 10 cycles and stores round keys 0..10 in an internal bank. The bank is served to the encrypt/decrypt round engines through a registered random-access read port; decrypt reads indices 10 down to 0.

---
 rtl/aes128_key_expand_ctrl_if.sv | 25 ++
 rtl/aes128_key_expand_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_aes128_key_expand_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_key_expand_ctrl_if.sv
// Key-load handshake, status and round-key read port for the AES-128 key schedule controller.
// The master side is the key source / round engine; the slave side is the controller.
interface aes128_key_expand_ctrl_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         rd_err;

    modport master (
        output key_in, key_valid, rd_en, rd_idx,
        input  key_ready, busy, done, keys_valid, rd_data, rd_valid, rd_err
    );

    modport slave (
        input  key_in, key_valid, rd_en, rd_idx,
        output key_ready, busy, done, keys_valid, rd_data, rd_valid, rd_err
    );
endinterface

// File: rtl/aes128_key_expand_ctrl.sv
// Sequential AES-128 key schedule: one shared RotWord/SubWord/Rcon stage iterated over
// ten cycles, round keys 0..10 held in a bank behind a registered random-access read port.
module aes128_key_expand_ctrl #(
    parameter int KEY_W  = 128,
    parameter int NUM_RK = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    aes128_key_expand_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [3:0]         round_r;
    logic [3:0]         round_s;
    logic               keys_valid_r;
    logic               keys_valid_s;
    logic               done_r;
    logic               done_s;
    logic               key_ready_r;
    logic               busy_r;
    logic               accept_s;
    logic               expand_s;
    logic [KEY_W-1:0]   rk_r [NUM_RK];
    logic [KEY_W-1:0]   prev_rk_s;
    logic [KEY_W-1:0]   next_rk_s;
    logic [KEY_W-1:0]   rd_word_s;
    logic [KEY_W-1:0]   rd_data_r;
    logic               rd_valid_r;
    logic               rd_err_r;
    logic [31:0]        temp_s;
    logic [31:0]        w0_s;
    logic [31:0]        w1_s;
    logic [31:0]        w2_s;
    logic [31:0]        w3_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = b[i] ? (p ^ aa) : p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as SubBytes requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            r = (i != 0) ? gf_mul(r, x) : r;
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // keyOperations: SubWord(RotWord(w)) ^ {Rcon(r), 24'h0}.
    function automatic logic [31:0] key_ops(input logic [31:0] w, input logic [3:0] r);
        logic [31:0] rot;
        rot = {w[23:0], w[31:24]};
        return {sbox(rot[31:24]) ^ rcon(r), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    endfunction

    // Next-state and control decode for the expansion sequencer.
    always_comb begin
        state_s      = state_r;
        round_s      = round_r;
        keys_valid_s = keys_valid_r;
        done_s       = 1'b0;
        accept_s     = 1'b0;
        expand_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_READY: begin
                if (bus.key_valid) begin
                    accept_s     = 1'b1;
                    state_s      = ST_EXPAND;
                    round_s      = 4'd1;
                    keys_valid_s = 1'b0;
                end else begin
                    state_s      = state_r;
                end
            end
            ST_EXPAND: begin
                expand_s = 1'b1;
                if (round_r >= 4'd10) begin
                    state_s      = ST_READY;
                    round_s      = 4'd11;
                    keys_valid_s = 1'b1;
                    done_s       = 1'b1;
                end else begin
                    round_s      = round_r + 4'd1;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                round_s      = 4'd0;
                keys_valid_s = 1'b0;
            end
        endcase
    end

    // Sequencer state, round counter and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            round_r      <= 4'd0;
            keys_valid_r <= 1'b0;
            done_r       <= 1'b0;
            key_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            round_r      <= round_s;
            keys_valid_r <= keys_valid_s;
            done_r       <= done_s;
            key_ready_r  <= (state_s != ST_EXPAND);
            busy_r       <= (state_s == ST_EXPAND);
        end
    end

    // Select the previous round key (rk[round-1]) and the requested read word.
    always_comb begin
        prev_rk_s = '0;
        rd_word_s = '0;
        for (int k = 0; k < NUM_RK; k++) begin
            prev_rk_s = (round_r == 4'(k + 1))  ? rk_r[k] : prev_rk_s;
            rd_word_s = (bus.rd_idx == 4'(k))   ? rk_r[k] : rd_word_s;
        end
    end

    // One round of the word recurrence on top of the shared keyOperations stage.
    always_comb begin
        temp_s    = key_ops(prev_rk_s[31:0], round_r);
        w0_s      = prev_rk_s[127:96] ^ temp_s;
        w1_s      = w0_s ^ prev_rk_s[95:64];
        w2_s      = w1_s ^ prev_rk_s[63:32];
        w3_s      = w2_s ^ prev_rk_s[31:0];
        next_rk_s = {w0_s, w1_s, w2_s, w3_s};
    end

    // Round-key bank; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            rk_r[0] <= bus.key_in;
        end
        for (int k = 1; k < NUM_RK; k++) begin
            if (expand_s && (round_r == 4'(k))) begin
                rk_r[k] <= next_rk_s;
            end
        end
    end

    // Registered read port; uses pre-edge bank and keys_valid so a rekey never corrupts a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            rd_err_r   <= 1'b0;
        end else if (bus.rd_en) begin
            rd_valid_r <= 1'b1;
            if (keys_valid_r && (bus.rd_idx <= 4'd10)) begin
                rd_data_r <= rd_word_s;
                rd_err_r  <= 1'b0;
            end else begin
                rd_data_r <= '0;
                rd_err_r  <= 1'b1;
            end
        end else begin
            rd_valid_r <= 1'b0;
            rd_err_r   <= 1'b0;
        end
    end

    assign bus.key_ready  = key_ready_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.keys_valid = keys_valid_r;
    assign bus.rd_data    = rd_data_r;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.rd_err     = rd_err_r;

endmodule

// File: tb/tb_aes128_key_expand_ctrl.sv
// Self-checking bench for aes128_key_expand_ctrl against a FIPS-197 word-array key schedule model.
module tb_aes128_key_expand_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    aes128_key_expand_ctrl_if bus();

    aes128_key_expand_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    byte unsigned  sbox_t [256];
    logic [127:0]  exp_rk [11];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        int p;
        int x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) == 1) p = p ^ x;
            x = x << 1;
            if (x > 255) x = (x ^ 'h11b);
        end
        return p;
    endfunction

    // Build the S-box by brute-force inversion and the FIPS-197 bitwise affine map.
    task automatic build_sbox();
        int inv;
        int s;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
            s = 0;
            for (int i = 0; i < 8; i++) begin
                s |= ((((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8))
                      ^ (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1) << i);
            end
            sbox_t[x] = byte'(s);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        int          rc;
        rc = 1;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc[7:0], 24'h000000};
                rc = gmul(rc, 2);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_key(input logic [127:0] key, input bit hold);
        bus.key_in    = key;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = hold;
    endtask

    // Wait for done after an accept edge, checking status each cycle; optionally scramble key_in.
    task automatic wait_done(input bit scramble, output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            check("busy_exp", bus.busy, 1);
            check("kready_exp", bus.key_ready, 0);
            check("kvalid_exp", bus.keys_valid, 0);
            if (scramble) bus.key_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
            lat++;
        end
        check("latency", 128'(lat), 128'd10);
        check("kvalid_done", bus.keys_valid, 1);
        check("busy_done", bus.busy, 0);
        check("kready_done", bus.key_ready, 1);
    endtask

    task automatic read_all(input bit desc);
        int idx;
        for (int i = 0; i < 11; i++) begin
            idx = desc ? 10 - i : i;
            bus.rd_en  = 1'b1;
            bus.rd_idx = 4'(idx);
            tick();
            check("rd_valid", bus.rd_valid, 1);
            check("rd_err", bus.rd_err, 0);
            check($sformatf("rk%0d", idx), bus.rd_data, exp_rk[idx]);
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic read_one(input int idx, input logic [127:0] exp_data, input bit exp_err);
        bus.rd_en  = 1'b1;
        bus.rd_idx = 4'(idx);
        tick();
        bus.rd_en  = 1'b0;
        check("rd1_valid", bus.rd_valid, 1);
        check("rd1_err", bus.rd_err, 128'(exp_err));
        check($sformatf("rd1_data%0d", idx), bus.rd_data, exp_data);
    endtask

    initial begin
        int           lat;
        int           dones;
        logic [127:0] k;
        logic [127:0] old_rk0;
        logic [127:0] old_rk10;
        int           idx;

        total = 0;
        bad   = 0;
        build_sbox();
        rst_n         = 1'b0;
        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_idx    = 4'd0;
        #22;
        check("rst_kready", bus.key_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_kvalid", bus.keys_valid, 0);
        check("rst_rdvalid", bus.rd_valid, 0);
        check("rst_rderr", bus.rd_err, 0);
        check("rst_rddata", bus.rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Read before any expansion is illegal.
        read_one(3, 128'h0, 1'b1);
        tick();
        check("idle_rdvalid", bus.rd_valid, 0);

        // FIPS-197 vector.
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        model_expand(k);
        check("model_rk1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("model_rk10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        start_key(k, 1'b0);
        wait_done(1'b0, lat);
        tick();
        check("done_pulse", bus.done, 0);
        read_one(0, k, 1'b0);
        read_one(1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0);
        read_one(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);
        tick();
        check("hold_rdvalid", bus.rd_valid, 0);
        check("hold_rderr", bus.rd_err, 0);
        check("hold_rddata", bus.rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_one(12, 128'h0, 1'b1);
        read_one(15, 128'h0, 1'b1);

        // All-zero key, descending back-to-back reads.
        model_expand(128'h0);
        start_key(128'h0, 1'b0);
        wait_done(1'b0, lat);
        check("zero_rk1", exp_rk[1], 128'h62636363626363636263636362636363);
        check("zero_rk10", exp_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        read_all(1'b1);

        // key_valid held through EXPAND with a changing key_in; second key taken only once READY.
        k = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k);
        start_key(k, 1'b1);
        wait_done(1'b1, lat);
        old_rk10      = exp_rk[10];
        k             = {$urandom, $urandom, $urandom, $urandom};
        bus.key_in    = k;
        bus.rd_en     = 1'b1;
        bus.rd_idx    = 4'd10;
        tick();
        bus.key_valid = 1'b0;
        bus.rd_en     = 1'b0;
        check("hold_old_rk10", bus.rd_data, old_rk10);
        check("hold_old_err", bus.rd_err, 0);
        model_expand(k);
        wait_done(1'b0, lat);
        read_all(1'b0);

        // Rekey in READY with a same-edge read of index 0.
        old_rk0       = exp_rk[0];
        k             = {$urandom, $urandom, $urandom, $urandom};
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        bus.rd_en     = 1'b1;
        bus.rd_idx    = 4'd0;
        tick();
        bus.key_valid = 1'b0;
        bus.rd_en     = 1'b0;
        check("rekey_rdvalid", bus.rd_valid, 1);
        check("rekey_rderr", bus.rd_err, 0);
        check("rekey_old_rk0", bus.rd_data, old_rk0);
        model_expand(k);
        wait_done(1'b0, lat);
        read_all(1'b0);

        // Asynchronous reset mid-expansion.
        start_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_kready", bus.key_ready, 1);
        check("arst_kvalid", bus.keys_valid, 0);
        check("arst_done", bus.done, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        check("arst_no_done", 128'(dones), 128'd0);
        check("arst_kvalid2", bus.keys_valid, 0);
        check("arst_busy2", bus.busy, 0);
        k = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k);
        start_key(k, 1'b0);
        wait_done(1'b0, lat);
        read_all(1'b0);

        // Random keys with random reads, including out-of-range indices.
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k);
            start_key(k, 1'b0);
            wait_done(1'b0, lat);
            for (int j = 0; j < 8; j++) begin
                idx = int'($urandom_range(0, 15));
                if (idx <= 10) read_one(idx, exp_rk[idx], 1'b0);
                else read_one(idx, 128'h0, 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
